// File: rtl/device_mmio.sv
// device_mmio: LED, 7-segment, switch, free-running timer and UART-TX registers with one-cycle read latency.
// Optional feature: define DEVICE_TIMER_IRQ_EN to add TIMER_CMP (0x18) and the sticky timer_irq.
module device_mmio #(
  parameter int CLK_DIV = 434,
  parameter int LED_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             device_ren,
  input  logic             device_wen,
  input  logic [31:0]      common_addr,
  input  logic [31:0]      common_wdata,
  input  logic [3:0]       common_wstrb,
  output logic [31:0]      device_rdata,
  output logic [LED_W-1:0] led,
  output logic [31:0]      seg,
  input  logic [LED_W-1:0] sw,
  output logic             uart_tx,
  output logic             timer_irq
);

  localparam logic [5:0]  A_LED   = 6'h00;
  localparam logic [5:0]  A_SEG   = 6'h01;
  localparam logic [5:0]  A_SW    = 6'h02;
  localparam logic [5:0]  A_TIMER = 6'h03;
  localparam logic [5:0]  A_UDATA = 6'h04;
  localparam logic [5:0]  A_USTAT = 6'h05;
  localparam logic [5:0]  A_TCMP  = 6'h06;
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_e;

  logic [5:0]       word;
  logic [31:0]      wmask;
  logic             udata_wr;
  logic             timer_wr;
  logic             irq_bit;
  logic             unused_addr_bits;

  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      seg_q, seg_d;
  logic [31:0]      timer_q, timer_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      rd_val;
  logic [LED_W-1:0] sw_meta_q, sw_sync_q;

  uart_state_e      state_q, state_d;
  logic [15:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_q, tx_d;
  logic             uart_busy;
  logic             bit_done;

  assign word             = common_addr[7:2];
  assign unused_addr_bits = ^{common_addr[31:8], common_addr[1:0]};
  assign wmask            = {{8{common_wstrb[3]}}, {8{common_wstrb[2]}},
                             {8{common_wstrb[1]}}, {8{common_wstrb[0]}}};
  assign udata_wr         = device_wen && (word == A_UDATA) && common_wstrb[0];
  assign timer_wr         = device_wen && (word == A_TIMER) && (|common_wstrb);
  assign uart_busy        = (state_q != U_IDLE);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

`ifdef DEVICE_TIMER_IRQ_EN
  logic [31:0] cmp_q, cmp_d;
  logic        irq_q, irq_d;
  logic        irq_clr;

  assign irq_clr = device_wen && (word == A_USTAT) && common_wstrb[0] && common_wdata[1];

  always_comb begin
    cmp_d = cmp_q;
    irq_d = irq_q;
    if (device_wen && (word == A_TCMP)) cmp_d = merge_bytes(cmp_q, common_wdata, wmask);
    if (irq_clr) irq_d = 1'b0;
    // Set after clear so a coincident match wins over the software clear.
    if (timer_q == cmp_q) irq_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q <= 32'hFFFF_FFFF;
      irq_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      irq_q <= irq_d;
    end
  end

  assign irq_bit = irq_q;
`else
  assign irq_bit = 1'b0;
`endif

  assign timer_irq = irq_bit;

  // NOTE: every always_comb output gets a default on entry, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    led_d   = led_q;
    seg_d   = seg_q;
    timer_d = timer_q + 32'd1;
    if (device_wen && (word == A_LED)) begin
      led_d = (led_q & ~wmask[LED_W-1:0]) | (common_wdata[LED_W-1:0] & wmask[LED_W-1:0]);
    end
    if (device_wen && (word == A_SEG)) seg_d = merge_bytes(seg_q, common_wdata, wmask);
    if (timer_wr) timer_d = merge_bytes(timer_q, common_wdata, wmask);
  end

  // Read mux sees only current register values, so a same-cycle write is not visible.
  always_comb begin
    rd_val = '0;
    case (word)
      A_LED:   rd_val[LED_W-1:0] = led_q;
      A_SEG:   rd_val = seg_q;
      A_SW:    rd_val[LED_W-1:0] = sw_sync_q;
      A_TIMER: rd_val = timer_q;
      A_USTAT: rd_val = {30'd0, irq_bit, uart_busy};
`ifdef DEVICE_TIMER_IRQ_EN
      A_TCMP:  rd_val = cmp_q;
`endif
      default: rd_val = '0;
    endcase
    rdata_d = device_ren ? rd_val : rdata_q;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 16'd1;
    bit_idx_d = bit_idx_q;
    tx_byte_d = tx_byte_q;
    bit_done  = (bit_cnt_q == DIV_LAST);
    case (state_q)
      U_IDLE: begin
        bit_cnt_d = '0;
        bit_idx_d = '0;
        if (udata_wr) begin
          state_d   = U_START;
          tx_byte_d = common_wdata[7:0];
        end
      end
      U_START: begin
        if (bit_done) begin
          state_d   = U_DATA;
          bit_cnt_d = '0;
          bit_idx_d = '0;
        end
      end
      U_DATA: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = U_STOP;
        end
      end
      U_STOP: begin
        if (bit_done) begin
          state_d   = U_IDLE;
          bit_cnt_d = '0;
        end
      end
      default: state_d = U_IDLE;
    endcase
  end

  // The line level is derived from the next state and registered, keeping uart_tx glitch-free.
  always_comb begin
    case (state_d)
      U_START: tx_d = 1'b0;
      U_DATA:  tx_d = tx_byte_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= '0;
      seg_q     <= '0;
      timer_q   <= '0;
      rdata_q   <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      state_q   <= U_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      tx_byte_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      led_q     <= led_d;
      seg_q     <= seg_d;
      timer_q   <= timer_d;
      rdata_q   <= rdata_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_byte_q <= tx_byte_d;
      tx_q      <= tx_d;
    end
  end

  assign device_rdata = rdata_q;
  assign led          = led_q;
  assign seg          = seg_q;
  assign uart_tx      = tx_q;

endmodule
